// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch controller and its
// prefetch buffer.
package ifetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int INS_BYTES = 4;
  localparam int ENTRY_W   = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-side bus bundle: memory request/response, decode handshake and the
// redirect from execute.
interface ifetch_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    output ins_valid,
    output ins,
    output ins_pc,
    input  ins_ready,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output resp_valid,
    output resp_data,
    input  ins_valid,
    input  ins,
    input  ins_pc,
    output ins_ready,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous circular FIFO with a flush that empties it in one cycle.
// The head entry is presented combinationally.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one outstanding word request, prefetch buffer
// toward decode, and redirect handling that discards in-flight responses.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic     clk,
  input logic     rst,
  ifetch_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      pc;
  logic [31:0]      pc_next;
  logic             req_valid_c;
  logic             handshake;
  logic             room;
  logic             push;
  logic             pop;
  logic             flush;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign room        = (fifo_count < CNT_W'(FIFO_DEPTH));
  assign req_valid_c = (state == FETCH) && room && !rst;
  assign handshake   = req_valid_c && bus.req_ready;

  assign bus.req_valid = req_valid_c;
  assign bus.req_addr  = pc;
  assign bus.ins_valid = !fifo_empty && !rst;
  assign bus.ins       = head_entry.ins;
  assign bus.ins_pc    = head_entry.pc;

  // Decode may not retire the head on a redirect cycle; the flush wins.
  assign pop = bus.ins_valid && bus.ins_ready && !bus.redirect_valid;

  assign push_entry = '{pc: pc, ins: bus.resp_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= align_pc(RESET_PC);
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Redirect outranks everything; the only question is whether a response is
  // still owed by memory, which decides between FETCH and DRAIN.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    push       = 1'b0;
    flush      = 1'b0;
    if (bus.redirect_valid) begin
      flush   = 1'b1;
      pc_next = align_pc(bus.redirect_pc);
      unique case (state)
        FETCH:       state_next = handshake ? DRAIN : FETCH;
        WAIT, DRAIN: state_next = bus.resp_valid ? FETCH : DRAIN;
        default:     state_next = FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (handshake) state_next = WAIT;
        end
        WAIT: begin
          if (bus.resp_valid) begin
            push       = 1'b1;
            pc_next    = pc + 32'(INS_BYTES);
            state_next = FETCH;
          end
        end
        DRAIN: begin
          if (bus.resp_valid) state_next = FETCH;
        end
        default: state_next = FETCH;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Requests are only issued with room to spare, so a push never meets a full buffer.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (!fifo_full);
  end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl: a small memory model answers requests and
// every address and decoded instruction is checked against queued expectations.
module tb_ifetch_ctrl;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ifetch_if bus ();

  ifetch_ctrl #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  int          cyc      = 0;
  logic [31:0] addr_q[$];
  logic [63:0] ins_q[$];

  bit          mem_busy    = 1'b0;
  int          mem_cnt     = 0;
  int          mem_lat     = 1;
  logic [31:0] mem_addr    = '0;
  int          ready_block = 0;

  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_ins_valid;
  logic [31:0] s_ins_pc;
  int          acc_cycle   = -1;
  int          last_pop    = -1;
  bit          chk_spacing = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expectFetch(input logic [31:0] a, input bit to_decode);
    addr_q.push_back(a);
    if (to_decode) ins_q.push_back({a, mem_word(a)});
  endtask

  // One clock of stimulus: inputs change on the falling edge, then memory and
  // decode react to the settled outputs.
  task automatic applyStimulus(input logic rst_v, input logic rdr_v,
                               input logic [31:0] rdr_pc, input logic ir);
    @(negedge clk);
    cyc++;
    rst                = rst_v;
    bus.redirect_valid = rdr_v;
    bus.redirect_pc    = rdr_pc;
    bus.ins_ready      = ir;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_data  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end
    end
    #1;
    s_req_valid = bus.req_valid;
    s_req_addr  = bus.req_addr;
    s_ins_valid = bus.ins_valid;
    s_ins_pc    = bus.ins_pc;
    bus.req_ready = 1'b0;
    if (bus.req_valid) begin
      if (ready_block > 0) begin
        ready_block--;
      end else if (!mem_busy && addr_q.size() != 0) begin
        bus.req_ready = 1'b1;
        checkOutput("req_addr", 64'(bus.req_addr), 64'(addr_q.pop_front()));
        mem_busy  = 1'b1;
        mem_cnt   = mem_lat;
        mem_addr  = bus.req_addr;
        acc_cycle = cyc;
      end
    end
    if (bus.ins_valid && ir && !rdr_v) begin
      checkOutput("sb_has_entry", 64'(ins_q.size() != 0), 64'd1);
      if (ins_q.size() != 0)
        checkOutput("ins_entry", {bus.ins_pc, bus.ins}, ins_q.pop_front());
      if (chk_spacing && last_pop >= 0)
        checkOutput("pop_spacing", 64'(cyc - last_pop), 64'd2);
      last_pop = cyc;
    end
  endtask

  task automatic idle(input int n, input logic ir);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, ir);
  endtask

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_req_valid", 64'(s_req_valid), 64'd0);
      checkOutput("rst_ins_valid", 64'(s_ins_valid), 64'd0);
    end
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_addr_q"}, 64'(addr_q.size()), 64'd0);
    checkOutput({tag, "_ins_q"}, 64'(ins_q.size()), 64'd0);
    addr_q.delete();
    ins_q.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.resp_data      = '0;
    bus.ins_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Streaming with a zero-wait memory and an always-ready decoder.
    doReset(2);
    for (int i = 0; i < 4; i++) expectFetch(32'(i * 4), 1'b1);
    chk_spacing = 1'b1;
    last_pop    = -1;
    idle(12, 1'b1);
    chk_spacing = 1'b0;
    checkDrained("stream");

    // Decode stalled: buffer fills, then drains and refetch resumes.
    doReset(2);
    expectFetch(32'h0, 1'b1);
    expectFetch(32'h4, 1'b1);
    expectFetch(32'h8, 1'b1);
    idle(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      checkOutput("full_req_valid", 64'(s_req_valid), 64'd0);
      checkOutput("full_ins_valid", 64'(s_ins_valid), 64'd1);
      checkOutput("full_head_pc", 64'(s_ins_pc), 64'h0);
    end
    idle(1, 1'b1);
    idle(1, 1'b1);
    checkOutput("refill_req_valid", 64'(s_req_valid), 64'd1);
    checkOutput("refill_req_addr", 64'(s_req_addr), 64'h8);
    checkOutput("refill_accept_cycle", 64'(acc_cycle), 64'(cyc));
    idle(5, 1'b1);
    checkDrained("full");

    // Redirect while waiting; the late response must be discarded.
    doReset(2);
    mem_lat = 4;
    expectFetch(32'h0, 1'b0);
    expectFetch(32'h10, 1'b1);
    expectFetch(32'h14, 1'b1);
    idle(1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      checkOutput("drain_req_valid", 64'(s_req_valid), 64'd0);
      checkOutput("drain_ins_valid", 64'(s_ins_valid), 64'd0);
    end
    idle(14, 1'b1);
    mem_lat = 1;
    checkDrained("wait_redirect");

    // Redirect to an unaligned target coinciding with a response.
    doReset(2);
    expectFetch(32'h0, 1'b0);
    expectFetch(32'h4, 1'b0);
    expectFetch(32'h20, 1'b1);
    idle(3, 1'b0);
    checkOutput("pre_redirect_head", 64'(s_ins_pc), 64'h0);
    applyStimulus(1'b0, 1'b1, 32'h23, 1'b0);
    checkOutput("coincide_resp", 64'(bus.resp_valid), 64'd1);
    idle(1, 1'b1);
    checkOutput("flushed_ins_valid", 64'(s_ins_valid), 64'd0);
    checkOutput("post_redirect_req_valid", 64'(s_req_valid), 64'd1);
    checkOutput("post_redirect_req_addr", 64'(s_req_addr), 64'h20);
    idle(6, 1'b1);
    checkDrained("resp_redirect");

    // Memory holds off the request for five cycles.
    doReset(2);
    ready_block = 5;
    expectFetch(32'h0, 1'b1);
    expectFetch(32'h4, 1'b1);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      checkOutput("stall_req_valid", 64'(s_req_valid), 64'd1);
      checkOutput("stall_req_addr", 64'(s_req_addr), 64'h0);
    end
    idle(1, 1'b1);
    checkOutput("stall_accept_cycle", 64'(acc_cycle), 64'(cyc));
    idle(8, 1'b1);
    checkDrained("stall");

    // Reset during DRAIN; the stale response arrives after release.
    doReset(2);
    mem_lat = 4;
    expectFetch(32'h0, 1'b0);
    idle(1, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("drain_rst_req_valid", 64'(s_req_valid), 64'd0);
      checkOutput("drain_rst_ins_valid", 64'(s_ins_valid), 64'd0);
    end
    mem_lat = 1;
    expectFetch(RESET_PC, 1'b1);
    expectFetch(RESET_PC + 32'h4, 1'b1);
    idle(1, 1'b1);
    checkOutput("late_resp_present", 64'(bus.resp_valid), 64'd1);
    checkOutput("after_rst_req_valid", 64'(s_req_valid), 64'd1);
    checkOutput("after_rst_req_addr", 64'(s_req_addr), 64'(RESET_PC));
    idle(8, 1'b1);
    checkDrained("drain_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
